// File: rtl/sync_pulse_pkg.sv
// sync_pulse_pkg: shared FSM state type and ctrl_word field positions
package sync_pulse_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, PULSE, GAP} state_t;
   localparam int ARM_BIT    = 0;
   localparam int MODE_BIT   = 1;
   localparam int SRC_BIT    = 2;
   localparam int PERIOD_LSB = 8;
   localparam int PERIOD_W   = 24;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus edge register, registered 1-cycle rise strobe
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);
   logic [2:0] s;
   always_ff @(posedge clk) begin
      if (rst) begin
         s    <= '0;
         rise <= 1'b0;
      end else begin
         s    <= {s[1:0], async_in};
         rise <= s[1] & ~s[2];
      end
   end
endmodule

// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen: armed one-shot/periodic sync pulse generator, immediate or external trigger
// SYNC_PULSE_GEN_CNT_EN enables the pulse_cnt counter; otherwise pulse_cnt is tied to 0.
module sync_pulse_gen #(
   parameter int PULSE_LEN = 4,
   parameter int PERIOD_W  = 24
) (
   input  logic        user_clk,
   input  logic        user_rst,
   input  logic [31:0] ctrl_word,
   input  logic        ext_sync_in,
   output logic        sync_out,
   output logic        armed,
   output logic [31:0] pulse_cnt
);
   import sync_pulse_pkg::*;
   localparam logic [PERIOD_W-1:0] PL = PERIOD_W'(PULSE_LEN);
   state_t state, nxt;
   logic [31:0] ctrl_q;
   logic [PERIOD_W-1:0] period_q, cnt, eff;
   logic mode_q, src_q, ext_rise, arm, arm_rise, start, pulse_end, gap_end;
   logic unused_ok;
   sync_edge_det u_sync (
      .clk(user_clk),
      .rst(user_rst),
      .async_in(ext_sync_in),
      .rise(ext_rise)
   );
   assign arm       = ctrl_word[ARM_BIT];
   assign arm_rise  = arm & ~ctrl_q[ARM_BIT];
   assign eff       = period_q > PL ? period_q : PL + 1'b1;
   assign pulse_end = cnt == PL - 1'b1;
   assign gap_end   = cnt == eff - 1'b1;
   assign start     = nxt == PULSE && state != PULSE;
   assign armed     = state != IDLE;
   assign unused_ok = ^{ctrl_q[31:1], ctrl_word[7:3]};
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:  nxt = arm_rise ? ARMED : IDLE;
         ARMED: nxt = !arm ? IDLE : (!src_q || ext_rise) ? PULSE : ARMED;
         PULSE: nxt = !pulse_end ? PULSE : (mode_q && arm) ? GAP : IDLE;
         GAP:   nxt = !arm ? IDLE : gap_end ? PULSE : GAP;
         default: nxt = IDLE;
      endcase
   end
   // cnt is zeroed on every PULSE entry so GAP compares against start-to-start spacing
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state    <= IDLE;
         ctrl_q   <= '0;
         mode_q   <= 1'b0;
         src_q    <= 1'b0;
         period_q <= '0;
         cnt      <= '0;
         sync_out <= 1'b0;
      end else begin
         state    <= nxt;
         ctrl_q   <= ctrl_word;
         sync_out <= nxt == PULSE;
         cnt      <= start ? '0 : cnt + 1'b1;
         if (state == IDLE && nxt == ARMED) begin
            mode_q   <= ctrl_word[MODE_BIT];
            src_q    <= ctrl_word[SRC_BIT];
            period_q <= ctrl_word[PERIOD_LSB +: PERIOD_W];
         end
      end
   end
`ifdef SYNC_PULSE_GEN_CNT_EN
   logic [31:0] pcnt;
   always_ff @(posedge user_clk) begin
      if (user_rst) pcnt <= '0;
      else if (start) pcnt <= pcnt + 1'b1;
   end
   assign pulse_cnt = pcnt;
`else
   assign pulse_cnt = '0;
`endif
endmodule

// File: tb/tb_sync_pulse_gen.sv
// tb_sync_pulse_gen: directed self-checking bench for sync_pulse_gen (PULSE_LEN=4)
module tb_sync_pulse_gen;
   logic user_clk = 1'b0;
   logic user_rst, ext_sync_in, sync_out, armed;
   logic [31:0] ctrl_word, pulse_cnt;
   int tests = 0, fails = 0, pulses = 0;

   always #5 user_clk = ~user_clk;

   sync_pulse_gen #(.PULSE_LEN(4), .PERIOD_W(24)) dut (
      .user_clk(user_clk),
      .user_rst(user_rst),
      .ctrl_word(ctrl_word),
      .ext_sync_in(ext_sync_in),
      .sync_out(sync_out),
      .armed(armed),
      .pulse_cnt(pulse_cnt)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge user_clk);
      #1;
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef SYNC_PULSE_GEN_CNT_EN
      return pulses;
`else
      return 32'd0;
`endif
   endfunction

   task automatic go_idle();
      ctrl_word = 32'h0;
      step(2);
   endtask

   task automatic test_reset();
      user_rst = 1'b1;
      ctrl_word = 32'h0;
      ext_sync_in = 1'b0;
      step(3);
      user_rst = 1'b0;
      step(1);
      tests++; if (sync_out !== 1'b0) begin fails++; $display("FAIL reset_sync: got %b want 0", sync_out); end
      tests++; if (armed !== 1'b0) begin fails++; $display("FAIL reset_armed: got %b want 0", armed); end
      tests++; if (pulse_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", pulse_cnt); end
   endtask

   task automatic test_one_shot();
      logic e;
      ctrl_word = 32'h1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         e = i >= 2 && i <= 5;
         tests++; if (sync_out !== e) begin fails++; $display("FAIL one_shot_sync cyc %0d: got %b want %b", i, sync_out, e); end
         e = i >= 1 && i <= 5;
         tests++; if (armed !== e) begin fails++; $display("FAIL one_shot_armed cyc %0d: got %b want %b", i, armed, e); end
      end
      pulses++;
      tests++; if (pulse_cnt !== exp_cnt()) begin fails++; $display("FAIL one_shot_cnt: got %0d want %0d", pulse_cnt, exp_cnt()); end
      go_idle();
   endtask

   task automatic test_periodic();
      logic e;
      ctrl_word = 32'h00000A03;
      for (int i = 1; i <= 47; i++) begin
         step(1);
         e = i >= 2 && (i - 2) % 10 < 4;
         tests++; if (sync_out !== e) begin fails++; $display("FAIL periodic_sync cyc %0d: got %b want %b", i, sync_out, e); end
         if (i == 7) ctrl_word = 32'h00000501;
      end
      tests++; if (armed !== 1'b1) begin fails++; $display("FAIL periodic_gap_armed: got %b want 1", armed); end
      ctrl_word = 32'h00000A02;
      step(1);
      pulses += 5;
      tests++; if (armed !== 1'b0) begin fails++; $display("FAIL periodic_disarm: got %b want 0", armed); end
      tests++; if (sync_out !== 1'b0) begin fails++; $display("FAIL periodic_disarm_sync: got %b want 0", sync_out); end
      tests++; if (pulse_cnt !== exp_cnt()) begin fails++; $display("FAIL periodic_cnt: got %0d want %0d", pulse_cnt, exp_cnt()); end
      go_idle();
   endtask

   task automatic test_clamp();
      logic e;
      ctrl_word = 32'h00000203;
      for (int i = 1; i <= 16; i++) begin
         step(1);
         e = i >= 2 && (i - 2) % 5 < 4;
         tests++; if (sync_out !== e) begin fails++; $display("FAIL clamp_sync cyc %0d: got %b want %b", i, sync_out, e); end
      end
      ctrl_word = 32'h00000202;
      step(1);
      pulses += 3;
      tests++; if (armed !== 1'b0) begin fails++; $display("FAIL clamp_disarm: got %b want 0", armed); end
      tests++; if (pulse_cnt !== exp_cnt()) begin fails++; $display("FAIL clamp_cnt: got %0d want %0d", pulse_cnt, exp_cnt()); end
      go_idle();
   endtask

   task automatic test_external();
      logic e;
      ctrl_word = 32'h00000005;
      ext_sync_in = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         tests++; if (sync_out !== 1'b0) begin fails++; $display("FAIL ext_wait_sync cyc %0d: got %b want 0", i, sync_out); end
         tests++; if (armed !== 1'b1) begin fails++; $display("FAIL ext_wait_armed cyc %0d: got %b want 1", i, armed); end
      end
      ext_sync_in = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step(1);
         e = i >= 4 && i <= 7;
         tests++; if (sync_out !== e) begin fails++; $display("FAIL ext_pulse_sync cyc %0d: got %b want %b", i, sync_out, e); end
      end
      pulses++;
      tests++; if (armed !== 1'b0) begin fails++; $display("FAIL ext_done_armed: got %b want 0", armed); end
      ext_sync_in = 1'b0;
      step(5);
      ext_sync_in = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step(1);
         tests++; if (sync_out !== 1'b0) begin fails++; $display("FAIL ext_second_edge cyc %0d: got %b want 0", i, sync_out); end
      end
      tests++; if (pulse_cnt !== exp_cnt()) begin fails++; $display("FAIL ext_cnt: got %0d want %0d", pulse_cnt, exp_cnt()); end
      ext_sync_in = 1'b0;
      go_idle();
   endtask

   task automatic test_disarm_pulse();
      logic e;
      ctrl_word = 32'h00000003;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         e = i >= 2 && i <= 5;
         tests++; if (sync_out !== e) begin fails++; $display("FAIL disarm_pulse_sync cyc %0d: got %b want %b", i, sync_out, e); end
         if (i == 3) ctrl_word = 32'h00000002;
      end
      pulses++;
      tests++; if (armed !== 1'b0) begin fails++; $display("FAIL disarm_pulse_idle: got %b want 0", armed); end
      go_idle();
   endtask

   task automatic test_reset_mid_pulse();
      logic e;
      ctrl_word = 32'h00000001;
      step(3);
      tests++; if (sync_out !== 1'b1) begin fails++; $display("FAIL rst_mid_pre: got %b want 1", sync_out); end
      user_rst = 1'b1;
      step(1);
      pulses = 0;
      tests++; if (sync_out !== 1'b0) begin fails++; $display("FAIL rst_mid_sync: got %b want 0", sync_out); end
      tests++; if (pulse_cnt !== 32'd0) begin fails++; $display("FAIL rst_mid_cnt: got %0d want 0", pulse_cnt); end
      user_rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step(1);
         e = i >= 2 && i <= 5;
         tests++; if (sync_out !== e) begin fails++; $display("FAIL rst_rearm_sync cyc %0d: got %b want %b", i, sync_out, e); end
      end
      pulses++;
      tests++; if (pulse_cnt !== exp_cnt()) begin fails++; $display("FAIL rst_rearm_cnt: got %0d want %0d", pulse_cnt, exp_cnt()); end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_clamp();
      test_external();
      test_disarm_pulse();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
